wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/rvj1_wb_pkg.sv | 21 ++
 rtl/wb_initiator_if.sv | 46 ++++
 rtl/wb_timeout_cnt.sv | 30 +++
 rtl/wb_initiator.sv | 119 +++++++++++
 tb/tb_wb_initiator.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvj1_wb_pkg.sv
// Shared Wishbone initiator definitions: FSM state encoding, bus widths, latched command layout.
package rvj1_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
    } wb_cmd_t;

endpackage

// File: rtl/wb_initiator_if.sv
// Command/response handshake plus Wishbone classic master signals of the initiator.
// master = the initiator itself, slave = the surrounding command source, response sink and bus slave.
interface wb_initiator_if;
    import rvj1_wb_pkg::*;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [WB_SEL_W-1:0] cmd_sel_i;
    logic [WB_ADR_W-1:0] cmd_adr_i;
    logic [WB_DAT_W-1:0] cmd_dat_i;

    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [WB_DAT_W-1:0] rsp_dat_o;
    logic                rsp_err_o;

    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [WB_SEL_W-1:0] wbm_sel_o;
    logic [WB_ADR_W-1:0] wbm_adr_o;
    logic [WB_DAT_W-1:0] wbm_dat_o;
    logic [WB_DAT_W-1:0] wbm_dat_i;
    logic                wbm_ack_i;
    logic                wbm_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        input  rsp_ready_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        output rsp_ready_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle timeout counter: clear wins over enable, saturates at LIMIT instead of wrapping.
// o_tc flags the last allowed wait cycle (count == LIMIT-1), combinationally from the count register.
module wb_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_sat;

    assign w_sat = (r_cnt == CW'(LIMIT));
    assign o_tc  = (r_cnt == CW'(LIMIT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_sat) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: stb rises the cycle after cmd accept, rsp_valid the cycle after ack/err/timeout.
// Response is held until rsp_ready; cmd_ready is low from accept until the response handshake.
module wb_initiator
    import rvj1_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_initiator_if.master wbi,
    output logic           busy_o
);

    wb_state_t           r_state;
    wb_state_t           w_state_nxt;
    wb_cmd_t             r_cmd;
    logic [WB_DAT_W-1:0] r_rsp_dat;
    logic                r_rsp_err;

    logic w_in_bus;
    logic w_accept;
    logic w_cnt_en;
    logic w_tc;
    logic w_bus_done;

    assign w_in_bus   = (r_state == ST_BUS);
    assign w_accept   = (r_state == ST_IDLE) && wbi.cmd_valid_i;
    assign w_cnt_en   = w_in_bus && !wbi.wbm_ack_i && !wbi.wbm_err_i;
    assign w_bus_done = wbi.wbm_ack_i || wbi.wbm_err_i || w_tc;

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_clr (w_accept),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (wbi.cmd_valid_i)  w_state_nxt = ST_BUS;
            ST_BUS:  if (w_bus_done)       w_state_nxt = ST_RESP;
            ST_RESP: if (wbi.rsp_ready_i)  w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // cyc/stb decode straight from the state register, so reset drops them without waiting for a clock
    always_comb begin
        wbi.cmd_ready_o = 1'b0;
        wbi.wbm_cyc_o   = 1'b0;
        wbi.wbm_stb_o   = 1'b0;
        wbi.rsp_valid_o = 1'b0;
        busy_o          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                wbi.cmd_ready_o = 1'b1;
                busy_o          = 1'b0;
            end
            ST_BUS: begin
                wbi.wbm_cyc_o = 1'b1;
                wbi.wbm_stb_o = 1'b1;
            end
            ST_RESP: begin
                wbi.rsp_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign wbi.wbm_we_o  = r_cmd.we;
    assign wbi.wbm_sel_o = r_cmd.sel;
    assign wbi.wbm_adr_o = r_cmd.adr;
    assign wbi.wbm_dat_o = r_cmd.dat;
    assign wbi.rsp_dat_o = r_rsp_dat;
    assign wbi.rsp_err_o = r_rsp_err;

    // priority: err beats ack, ack beats the timeout terminal count
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cmd     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd.we  <= wbi.cmd_we_i;
                r_cmd.sel <= wbi.cmd_sel_i;
                r_cmd.adr <= wbi.cmd_adr_i;
                r_cmd.dat <= wbi.cmd_dat_i;
            end
            if (w_in_bus) begin
                if (wbi.wbm_err_i) begin
                    r_rsp_dat <= '0;
                    r_rsp_err <= 1'b1;
                end else if (wbi.wbm_ack_i) begin
                    r_rsp_dat <= r_cmd.we ? '0 : wbi.wbm_dat_i;
                    r_rsp_err <= 1'b0;
                end else if (w_tc) begin
                    r_rsp_dat <= '0;
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator: transaction-level model predicts stb length and response, checked every cycle.
module tb_wb_initiator;

    localparam int T        = 4;
    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_BOTH   = 2;
    localparam int K_SILENT = 3;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          wt;
        int          kind;
        int          stall;
    } txn_t;

    logic clk;
    logic rst;
    logic busy;

    wb_initiator_if bus();

    wb_initiator #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbi      (bus),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    txn_t pend[$];
    txn_t txq[$];
    txn_t cur_cmd;
    logic presenting = 1'b0;
    logic in_bus     = 1'b0;
    int   bidx       = 0;
    int   stall      = 0;
    int   pres_pct   = 100;
    int   rdy_pct    = 100;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // A slave that answers at wait index wt within T stb cycles wins; otherwise the bus times out after T cycles.
    function automatic logic responds(input txn_t t);
        return (t.kind != K_SILENT) && (t.wt < T);
    endfunction

    function automatic int exp_stb(input txn_t t);
        return responds(t) ? t.wt + 1 : T;
    endfunction

    function automatic logic exp_err(input txn_t t);
        return responds(t) ? (t.kind != K_ACK) : 1'b1;
    endfunction

    function automatic logic [31:0] exp_dat(input txn_t t);
        return (exp_err(t) || t.we) ? 32'h0 : t.rdata;
    endfunction

    function automatic txn_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [31:0] rd,
                                input int wt, input int kind, input int stl);
        txn_t t;
        t.we = we; t.sel = sel; t.adr = adr; t.dat = dat; t.rdata = rd;
        t.wt = wt; t.kind = kind; t.stall = stl;
        return t;
    endfunction

    task automatic drive_cmd();
        bus.cmd_valid_i = presenting;
        if (presenting) begin
            bus.cmd_we_i  = cur_cmd.we;
            bus.cmd_sel_i = cur_cmd.sel;
            bus.cmd_adr_i = cur_cmd.adr;
            bus.cmd_dat_i = cur_cmd.dat;
        end else begin
            bus.cmd_we_i  = ($urandom_range(1) == 1);
            bus.cmd_sel_i = 4'($urandom);
            bus.cmd_adr_i = $urandom;
            bus.cmd_dat_i = $urandom;
        end
    endtask

    // One clock: account the handshakes of the edge just passed, then drive the next cycle's inputs.
    task automatic step();
        logic acc;
        logic rh;
        @(posedge clk);
        #1;
        acc = presenting && (txq.size() == 0) && !rst;
        rh  = bus.rsp_ready_i && (txq.size() > 0) && !in_bus && !rst;
        if (in_bus) begin
            bidx++;
            if (bidx >= exp_stb(txq[0])) begin
                in_bus = 1'b0;
                stall  = txq[0].stall;
            end
        end
        if (rh) void'(txq.pop_front());
        if (acc) begin
            txq.push_back(cur_cmd);
            in_bus     = 1'b1;
            bidx       = 0;
            presenting = 1'b0;
        end
        if (!presenting && (pend.size() > 0) && ($urandom_range(99) < pres_pct)) begin
            cur_cmd    = pend.pop_front();
            presenting = 1'b1;
        end
        drive_cmd();
        bus.wbm_dat_i = $urandom;
        if (in_bus && (bidx == txq[0].wt) && (txq[0].kind != K_SILENT)) begin
            bus.wbm_ack_i = (txq[0].kind != K_ERR);
            bus.wbm_err_i = (txq[0].kind != K_ACK);
            bus.wbm_dat_i = txq[0].rdata;
        end else if (in_bus) begin
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
        end else begin
            bus.wbm_ack_i = ($urandom_range(2) == 0);
            bus.wbm_err_i = ($urandom_range(3) == 0);
        end
        if ((txq.size() > 0) && !in_bus && (stall > 0)) begin
            bus.rsp_ready_i = 1'b0;
            stall--;
        end else begin
            bus.rsp_ready_i = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (((pend.size() + txq.size()) != 0 || presenting) && n < budget) begin
            step();
            n++;
        end
        chk1("drain_done", ((pend.size() + txq.size()) == 0) && !presenting, 1'b1);
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            chk1 ("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
            chk1 ("rst_cyc",       bus.wbm_cyc_o,   1'b0);
            chk1 ("rst_stb",       bus.wbm_stb_o,   1'b0);
            chk1 ("rst_we",        bus.wbm_we_o,    1'b0);
            chk1 ("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
            chk1 ("rst_rsp_err",   bus.rsp_err_o,   1'b0);
            chk1 ("rst_busy",      busy,            1'b0);
            chk32("rst_rsp_dat",   bus.rsp_dat_o,   32'h0);
            chk32("rst_adr",       bus.wbm_adr_o,   32'h0);
            chk32("rst_dat",       bus.wbm_dat_o,   32'h0);
            chk32("rst_sel",       {28'h0, bus.wbm_sel_o}, 32'h0);
        end else if (txq.size() == 0) begin
            chk1("idle_cmd_ready", bus.cmd_ready_o, 1'b1);
            chk1("idle_cyc",       bus.wbm_cyc_o,   1'b0);
            chk1("idle_stb",       bus.wbm_stb_o,   1'b0);
            chk1("idle_rsp_valid", bus.rsp_valid_o, 1'b0);
            chk1("idle_busy",      busy,            1'b0);
        end else if (in_bus) begin
            t = txq[0];
            chk1 ("bus_cyc",       bus.wbm_cyc_o,   1'b1);
            chk1 ("bus_stb",       bus.wbm_stb_o,   1'b1);
            chk1 ("bus_we",        bus.wbm_we_o,    t.we);
            chk32("bus_sel",       {28'h0, bus.wbm_sel_o}, {28'h0, t.sel});
            chk32("bus_adr",       bus.wbm_adr_o,   t.adr);
            chk32("bus_dat",       bus.wbm_dat_o,   t.dat);
            chk1 ("bus_rsp_valid", bus.rsp_valid_o, 1'b0);
            chk1 ("bus_cmd_ready", bus.cmd_ready_o, 1'b0);
            chk1 ("bus_busy",      busy,            1'b1);
        end else begin
            t = txq[0];
            chk1 ("rsp_cyc",       bus.wbm_cyc_o,   1'b0);
            chk1 ("rsp_stb",       bus.wbm_stb_o,   1'b0);
            chk1 ("rsp_valid",     bus.rsp_valid_o, 1'b1);
            chk32("rsp_dat",       bus.rsp_dat_o,   exp_dat(t));
            chk1 ("rsp_err",       bus.rsp_err_o,   exp_err(t));
            chk1 ("rsp_cmd_ready", bus.cmd_ready_o, 1'b0);
            chk1 ("rsp_busy",      busy,            1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_pass %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t_wr, t_rd, t_to, t_both, t_tc, t_bp, t_bp2, t_rs, t_after;
        int   n;
        int   r;

        t_wr    = mk(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, K_ACK,    0);
        t_rd    = mk(1'b0, 4'hF, 32'h3000_0014, 32'h0BAD_0BAD, 32'h1234_5678, 3, K_ACK,    0);
        t_to    = mk(1'b0, 4'h3, 32'h3000_0018, 32'h0000_0001, 32'hFFFF_FFFF, 9, K_SILENT, 0);
        t_both  = mk(1'b0, 4'hC, 32'h3000_001C, 32'h0000_0002, 32'hA5A5_A5A5, 0, K_BOTH,   0);
        t_tc    = mk(1'b0, 4'h1, 32'h3000_0020, 32'h0000_0003, 32'h0F0F_0F0F, 3, K_ACK,    0);
        t_bp    = mk(1'b0, 4'hF, 32'h3000_0024, 32'h0000_0004, 32'h8765_4321, 1, K_ACK,    5);
        t_bp2   = mk(1'b1, 4'h6, 32'h3000_0028, 32'hC0DE_C0DE, 32'h1111_2222, 0, K_ACK,    0);
        t_rs    = mk(1'b1, 4'hF, 32'h3000_002C, 32'h7777_7777, 32'h0,        0, K_SILENT, 0);
        t_after = mk(1'b0, 4'hF, 32'h3000_0030, 32'h0,        32'hCAFE_F00D, 1, K_ACK,    0);

        chk32("pin_wr_stb",   exp_stb(t_wr),   32'd1);
        chk32("pin_wr_dat",   exp_dat(t_wr),   32'h0);
        chk1 ("pin_wr_err",   exp_err(t_wr),   1'b0);
        chk32("pin_rd_stb",   exp_stb(t_rd),   32'd4);
        chk32("pin_rd_dat",   exp_dat(t_rd),   32'h1234_5678);
        chk32("pin_to_stb",   exp_stb(t_to),   32'd4);
        chk1 ("pin_to_err",   exp_err(t_to),   1'b1);
        chk32("pin_to_dat",   exp_dat(t_to),   32'h0);
        chk1 ("pin_both_err", exp_err(t_both), 1'b1);
        chk1 ("pin_tc_err",   exp_err(t_tc),   1'b0);

        rst = 1'b1;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        bus.wbm_dat_i   = 32'h0;
        presenting      = 1'b0;
        drive_cmd();
        repeat (3) @(posedge clk);
        #1;
        // first command is already offered when reset drops, so the first clean edge must take it
        cur_cmd    = t_wr;
        presenting = 1'b1;
        drive_cmd();
        rst = 1'b0;

        pend.push_back(t_rd);
        pend.push_back(t_to);
        pend.push_back(t_both);
        pend.push_back(t_tc);
        pend.push_back(t_bp);
        pend.push_back(t_bp2);
        drain(300);

        pres_pct = 60;
        rdy_pct  = 70;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(7));
            pend.push_back(mk($urandom_range(1) == 1, 4'($urandom), $urandom, $urandom, $urandom,
                              int'($urandom_range(5)),
                              (r < 5) ? K_ACK : (r == 5) ? K_ERR : (r == 6) ? K_BOTH : K_SILENT,
                              ($urandom_range(3) == 0) ? int'($urandom_range(5, 1)) : 0));
        end
        drain(6000);

        pres_pct = 100;
        rdy_pct  = 100;
        pend.push_back(t_rs);
        n = 0;
        while (!(in_bus && bidx == 1) && n < 50) begin
            step();
            n++;
        end
        chk1("mid_bus_reached", in_bus && (bidx == 1), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_cyc", bus.wbm_cyc_o, 1'b0);
        chk1("async_rst_stb", bus.wbm_stb_o, 1'b0);
        txq.delete();
        pend.delete();
        in_bus     = 1'b0;
        presenting = 1'b0;
        drive_cmd();
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        pend.push_back(t_after);
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
